// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM peripheral.
//   - Register word addresses
//   - CONFIG field bit positions
//   - Counting mode and direction enums
package pwm_pkg;

  localparam logic [3:0] ADDR_CONFIG  = 4'd0;
  localparam logic [3:0] ADDR_TOP     = 4'd1;
  localparam logic [3:0] ADDR_COUNTER = 4'd2;
  localparam logic [3:0] ADDR_CMP0    = 4'd3;

  localparam int CFG_EN   = 0;
  localparam int CFG_MODE = 1;
  localparam int CFG_INV  = 2;
  localparam int CFG_PRE  = 16;

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTRE = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

endpackage

// File: rtl/pwm_channel_compare.sv
// One PWM compare channel: active compare register, comparator, inversion
// and output flop.
//   clk, rst_n : clock, async active-low reset
//   load_i     : copy shadow compare into the active register
//   en_i       : peripheral enabled; when low the output idles at inv_i
//   inv_i      : output inversion
//   cmp_sh_i   : shadow compare value
//   cnt_i      : shared counter value
//   pwm_o      : registered PWM output
module pwm_channel_compare #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          en_i,
  input  logic          inv_i,
  input  logic [CW-1:0] cmp_sh_i,
  input  logic [CW-1:0] cnt_i,
  output logic          pwm_o
);

  logic [CW-1:0] cmp_act_q;
  logic          pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_act_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      if (load_i) cmp_act_q <= cmp_sh_i;
      // compare 0 is always high; compare > top never matches
      pwm_q <= en_i ? ((cnt_i >= cmp_act_q) ^ inv_i) : inv_i;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and edge/centre-aligned counter drive
// CHANNELS compare outputs. TOP/COMPARE are shadowed and copied into the
// active registers at each period boundary (or continuously while disabled).
//   clk, rst_n : clock, async active-low reset
//   reg_we     : single-cycle register write strobe
//   reg_addr   : word address
//   reg_wdata  : write data
//   reg_rdata  : combinational read data for reg_addr
//   pwm_o      : registered PWM outputs
//   period_o   : one-cycle pulse when the counter takes 0 at a boundary
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int COUNTER_WIDTH  = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_we,
  input  logic [3:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_o
);

  localparam int CW = COUNTER_WIDTH;
  localparam int PW = PRESCALE_WIDTH;

  logic                         en_q;
  mode_e                        mode_q;
  logic [CHANNELS-1:0]          inv_q;
  logic [PW-1:0]                psc_q, pre_q, pre_d;
  logic [CW-1:0]                cnt_q, cnt_d, cnt_inc;
  dir_e                         dir_q, dir_d;
  logic [CW-1:0]                top_sh_q, top_act_q;
  logic [CHANNELS-1:0][CW-1:0]  cmp_sh_q;
  logic                         per_q;
  logic                         bnd, load;
  logic                         wr_cfg, wr_top, wr_cnt;
  logic                         unused_wdata;

  assign wr_cfg  = reg_we && (reg_addr == ADDR_CONFIG);
  assign wr_top  = reg_we && (reg_addr == ADDR_TOP);
  assign wr_cnt  = reg_we && (reg_addr == ADDR_COUNTER);
  assign cnt_inc = cnt_q + 1'b1;
  assign unused_wdata = ^reg_wdata;

  // Prescaler and counter next state. A COUNTER write overrides any tick,
  // so no boundary is flagged in that cycle.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    pre_d = pre_q;
    bnd   = 1'b0;
    if (wr_cnt) begin
      cnt_d = '0;
      pre_d = '0;
      dir_d = DIR_UP;
    end else if (en_q) begin
      // >= so a prescale lowered below the running count still ticks
      if (pre_q >= psc_q) begin
        pre_d = '0;
        if (mode_q == MODE_EDGE) begin
          cnt_d = (cnt_q >= top_act_q) ? '0 : cnt_inc;
        end else if (dir_q == DIR_UP) begin
          if (cnt_q < top_act_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == top_act_q) dir_d = DIR_DOWN;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            dir_d = (cnt_q == CW'(1)) ? DIR_UP : DIR_DOWN;
          end
        end else begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) dir_d = DIR_UP;
        end
        bnd = (cnt_d == '0);
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Shadows flow into the active copies at a boundary, or every cycle while
  // disabled. A write in the boundary cycle lands in the shadow only.
  assign load = !en_q || bnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      mode_q    <= MODE_EDGE;
      inv_q     <= '0;
      psc_q     <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      top_sh_q  <= '0;
      top_act_q <= '0;
      cmp_sh_q  <= '0;
      per_q     <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      per_q <= bnd;
      if (load) top_act_q <= top_sh_q;
      if (wr_cfg) begin
        en_q   <= reg_wdata[CFG_EN];
        mode_q <= mode_e'(reg_wdata[CFG_MODE]);
        inv_q  <= reg_wdata[CFG_INV +: CHANNELS];
        psc_q  <= reg_wdata[CFG_PRE +: PW];
      end
      if (wr_top) top_sh_q <= reg_wdata[CW-1:0];
      for (int i = 0; i < CHANNELS; i++)
        if (reg_we && (reg_addr == 4'(int'(ADDR_CMP0) + i)))
          cmp_sh_q[i] <= reg_wdata[CW-1:0];
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_CONFIG: begin
        reg_rdata[CFG_EN]              = en_q;
        reg_rdata[CFG_MODE]            = mode_q;
        reg_rdata[CFG_INV +: CHANNELS] = inv_q;
        reg_rdata[CFG_PRE +: PW]       = psc_q;
      end
      ADDR_TOP:     reg_rdata[CW-1:0] = top_sh_q;
      ADDR_COUNTER: reg_rdata[CW-1:0] = cnt_q;
      default: ;
    endcase
    for (int i = 0; i < CHANNELS; i++)
      if (reg_addr == 4'(int'(ADDR_CMP0) + i)) reg_rdata[CW-1:0] = cmp_sh_q[i];
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel_compare #(.CW(CW)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .en_i    (en_q),
      .inv_i   (inv_q[g]),
      .cmp_sh_i(cmp_sh_q[g]),
      .cnt_i   (cnt_q),
      .pwm_o   (pwm_o[g])
    );
  end

  assign period_o = per_q;

endmodule
